mult_div_unit: RTL and testbench

//   Multicycle signed multiply/divide engine for MULT and DIV, sitting directly upstream of the HI/LO

---
 rtl/mult_div_unit_if.sv | 30 +++
 rtl/mult_div_unit.sv | 148 ++++++++++++++
 tb/tb_mult_div_unit.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Purpose: operand/result bundle between control and the multiply/divide engine.
// Latency: none, wires only.
// Backpressure: none; Start is a request pulse, Busy/Done report progress.
// Ports (master = control side, slave = engine side):
//   Start, Op, A, B        master -> slave  request, 0=MULT 1=DIV, operands
//   Busy, Done, DivZero    slave -> master  status
//   Hi, Lo                 slave -> master  result halves
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, DivZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, DivZero, Hi, Lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Purpose: multicycle signed MULT (radix-2 Booth) / DIV (restoring) feeding HI/LO.
// Latency: Start sampled at E0 -> Done in the cycle after E34 (E1 for divide-by-zero).
// Backpressure: none; Start while Busy is dropped, no queueing.
// Ports:
//   Clk, Reset       clock (rising edge), async active-low reset
//   bus (slave)      Start/Op/A/B in; Busy/Done/DivZero/Hi/Lo out, all registered
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      Clk,
    input  logic      Reset,
    mult_div_if.slave bus
);
    localparam int PW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, nextState;

    // Inputs are registered first so no input reaches an output combinationally;
    // this register stage is why Done lands one edge later than the state walk alone.
    logic             startQ, opQ;
    logic [WIDTH-1:0] aQ, bQ;

    logic             opR, signA, signB;
    logic [WIDTH-1:0] opB;          // MULT: raw B, DIV: |B|
    logic [PW-1:0]    p;            // shared shift datapath
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hiR, loR;
    logic             divZeroR;

    logic             accept, zeroDiv, loadRes;

    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH:0]   upperExt, bExt, boothSum;
    logic [PW-1:0]    multNext, shl, divNext;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] quoFix, remFix, resHi, resLo;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            startQ <= 1'b0;
            opQ    <= 1'b0;
            aQ     <= '0;
            bQ     <= '0;
        end else begin
            startQ <= bus.Start;
            opQ    <= bus.Op;
            aQ     <= bus.A;
            bQ     <= bus.B;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        zeroDiv   = 1'b0;
        loadRes   = 1'b0;
        case (state)
            IDLE, DONE: begin
                nextState = IDLE;
                if (startQ) begin
                    accept = 1'b1;
                    if (opQ && bQ == '0) begin
                        zeroDiv   = 1'b1;
                        nextState = DONE;
                    end else begin
                        nextState = CALC;
                    end
                end
            end
            CALC: if (cnt == CNT_W'(WIDTH - 1)) nextState = FIX;
            FIX: begin
                nextState = DONE;
                loadRes   = 1'b1;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        absA = aQ[WIDTH-1] ? -aQ : aQ;
        absB = bQ[WIDTH-1] ? -bQ : bQ;

        // Booth step on a 33-bit upper half so B = -2**31 cannot overflow the partial sum.
        upperExt = {p[PW-1], p[PW-1:WIDTH+1]};
        bExt     = {opB[WIDTH-1], opB};
        case (p[1:0])
            2'b01:   boothSum = upperExt + bExt;
            2'b10:   boothSum = upperExt - bExt;
            default: boothSum = upperExt;
        endcase
        multNext = {boothSum, p[WIDTH:1]};

        // Restoring step: remainder in p[63:32], quotient shifts in at p[0].
        shl     = {p[PW-2:0], 1'b0};
        diff    = {1'b0, shl[PW-1:WIDTH]} - {2'b00, opB};
        divNext = diff[WIDTH+1] ? shl : {diff[WIDTH:0], shl[WIDTH-1:1], 1'b1};

        quoFix = (signA ^ signB) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        remFix = signA ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
        resHi  = opR ? remFix : p[PW-1:WIDTH+1];
        resLo  = opR ? quoFix : p[WIDTH:1];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            opR      <= 1'b0;
            signA    <= 1'b0;
            signB    <= 1'b0;
            opB      <= '0;
            p        <= '0;
            cnt      <= '0;
            hiR      <= '0;
            loR      <= '0;
            divZeroR <= 1'b0;
        end else begin
            if (accept) begin
                opR      <= opQ;
                signA    <= aQ[WIDTH-1];
                signB    <= bQ[WIDTH-1];
                opB      <= opQ ? absB : bQ;
                p        <= opQ ? {{(WIDTH+1){1'b0}}, absA} : {{WIDTH{1'b0}}, aQ, 1'b0};
                cnt      <= '0;
                divZeroR <= zeroDiv;
            end else if (state == CALC) begin
                p   <= opR ? divNext : multNext;
                cnt <= cnt + 1'b1;
            end
            // Sign fix-up is folded into the load so Hi/Lo only ever see final values.
            if (loadRes) begin
                hiR <= resHi;
                loR <= resLo;
            end
        end
    end

    assign bus.Busy    = (state == CALC) || (state == FIX);
    assign bus.Done    = (state == DONE);
    assign bus.DivZero = divZeroR;
    assign bus.Hi      = hiR;
    assign bus.Lo      = loR;
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    logic Clk = 1'b0;
    logic Reset;

    mult_div_if #(.WIDTH(32)) bus();

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    int passCnt  = 0;
    int totalCnt = 0;
    logic [31:0] lastHi = 32'h0;
    logic [31:0] lastLo = 32'h0;

    // Reference: plain 64-bit arithmetic; SV signed division truncates toward zero
    // and the remainder takes the dividend's sign.
    task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el,
                         output int lat, output logic dz);
        longint sa, sb, pr, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lat = 34;
        dz  = 1'b0;
        if (!op) begin
            pr = sa * sb;
            eh = pr[63:32];
            el = pr[31:0];
        end else if (b == 32'h0) begin
            eh  = lastHi;
            el  = lastLo;
            lat = 1;
            dz  = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            el = q[31:0];
            eh = r[31:0];
        end
    endtask

    task automatic startOp(input logic op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
    endtask

    task automatic waitDone(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge Clk);
            #1;
            if (bus.Done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic runOp(input string name, input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int lat, n;
        logic dz;
        model(op, a, b, eh, el, lat, dz);
        startOp(op, a, b);
        waitDone(n);
        totalCnt++;
        if (n !== lat) $display("FAIL %s latency: got %0d expected %0d", name, n, lat);
        else passCnt++;
        totalCnt++;
        if (bus.Hi !== eh) $display("FAIL %s Hi: got %h expected %h", name, bus.Hi, eh);
        else passCnt++;
        totalCnt++;
        if (bus.Lo !== el) $display("FAIL %s Lo: got %h expected %h", name, bus.Lo, el);
        else passCnt++;
        totalCnt++;
        if (bus.DivZero !== dz) $display("FAIL %s DivZero: got %b expected %b", name, bus.DivZero, dz);
        else passCnt++;
        lastHi = eh;
        lastLo = el;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        totalCnt++;
        if ({bus.Busy, bus.Done, bus.DivZero} !== 3'b000)
            $display("FAIL reset flags: got %b expected 000", {bus.Busy, bus.Done, bus.DivZero});
        else passCnt++;
        totalCnt++;
        if (bus.Hi !== 32'h0) $display("FAIL reset Hi: got %h expected 0", bus.Hi);
        else passCnt++;
        totalCnt++;
        if (bus.Lo !== 32'h0) $display("FAIL reset Lo: got %h expected 0", bus.Lo);
        else passCnt++;
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_mult();
        runOp("mult_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD);
        runOp("mult_maxpos", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF);
        runOp("mult_minneg", 1'b0, 32'h80000000, 32'h80000000);
        runOp("mult_neg_pos", 1'b0, 32'h80000000, 32'h00000001);
    endtask

    task automatic test_div();
        runOp("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
        runOp("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE);
        runOp("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        runOp("div_min_min", 1'b1, 32'h80000000, 32'h80000000);
    endtask

    task automatic test_divzero();
        runOp("div_68_7", 1'b1, 32'd68, 32'd7);
        runOp("div_by_zero", 1'b1, 32'd123, 32'd0);
        runOp("after_divzero", 1'b0, 32'd2, 32'd3);
    endtask

    task automatic test_busy_ignore();
        logic [31:0] eh, el, gotHi, gotLo;
        int lat, first, doneCnt;
        logic dz;
        model(1'b0, 32'h0001_2345, 32'hFFFF_0F0F, eh, el, lat, dz);
        startOp(1'b0, 32'h0001_2345, 32'hFFFF_0F0F);
        first   = -1;
        doneCnt = 0;
        gotHi   = 32'h0;
        gotLo   = 32'h0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge Clk);
            #1;
            if (bus.Done) begin
                doneCnt++;
                if (first < 0) begin
                    first = n;
                    gotHi = bus.Hi;
                    gotLo = bus.Lo;
                end
            end
            if (n == 12) begin
                totalCnt++;
                if (bus.Busy !== 1'b1) $display("FAIL busy_mid_calc: got %b expected 1", bus.Busy);
                else passCnt++;
            end
            if (n == 9 || n == 19) begin
                bus.Start = 1'b1;
                bus.Op    = 1'b1;
                bus.A     = 32'h1234;
                bus.B     = 32'h7;
            end
            if (n == 10 || n == 20) bus.Start = 1'b0;
        end
        totalCnt++;
        if (doneCnt !== 1) $display("FAIL ignore_done_count: got %0d expected 1", doneCnt);
        else passCnt++;
        totalCnt++;
        if (first !== 34) $display("FAIL ignore_latency: got %0d expected 34", first);
        else passCnt++;
        totalCnt++;
        if ({gotHi, gotLo} !== {eh, el})
            $display("FAIL ignore_result: got %h_%h expected %h_%h", gotHi, gotLo, eh, el);
        else passCnt++;
        lastHi = eh;
        lastLo = el;
    endtask

    task automatic test_back_to_back();
        logic [31:0] eh1, el1, eh2, el2, h1, l1, h2, l2;
        int lat, first, second;
        logic dz;
        model(1'b1, 32'hFFFF_1000, 32'd37, eh1, el1, lat, dz);
        model(1'b0, 32'hFFFF_FFF0, 32'h0000_1001, eh2, el2, lat, dz);
        startOp(1'b1, 32'hFFFF_1000, 32'd37);
        first  = -1;
        second = -1;
        {h1, l1, h2, l2} = '0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge Clk);
            #1;
            if (bus.Done && first < 0) begin
                first = n;
                h1 = bus.Hi;
                l1 = bus.Lo;
                bus.Start = 1'b1;
                bus.Op    = 1'b0;
                bus.A     = 32'hFFFF_FFF0;
                bus.B     = 32'h0000_1001;
            end else if (bus.Done && second < 0) begin
                second = n;
                h2 = bus.Hi;
                l2 = bus.Lo;
                break;
            end
            if (first > 0 && n == first + 1) bus.Start = 1'b0;
        end
        bus.Start = 1'b0;
        totalCnt++;
        if (first !== 34) $display("FAIL b2b_first_latency: got %0d expected 34", first);
        else passCnt++;
        totalCnt++;
        if ({h1, l1} !== {eh1, el1}) $display("FAIL b2b_first_result: got %h_%h expected %h_%h", h1, l1, eh1, el1);
        else passCnt++;
        totalCnt++;
        if (second !== 69) $display("FAIL b2b_second_latency: got %0d expected 69", second);
        else passCnt++;
        totalCnt++;
        if ({h2, l2} !== {eh2, el2}) $display("FAIL b2b_second_result: got %h_%h expected %h_%h", h2, l2, eh2, el2);
        else passCnt++;
        lastHi = eh2;
        lastLo = el2;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_async_reset();
        runOp("pre_reset_mult", 1'b0, 32'd7, 32'hFFFFFFFD);
        startOp(1'b0, 32'd5, 32'd6);
        repeat (10) @(posedge Clk);
        #1;
        totalCnt++;
        if (bus.Busy !== 1'b1) $display("FAIL pre_reset_busy: got %b expected 1", bus.Busy);
        else passCnt++;
        #2;
        Reset = 1'b0;
        #1;
        totalCnt++;
        if ({bus.Busy, bus.Done} !== 2'b00) $display("FAIL async_reset_flags: got %b expected 00", {bus.Busy, bus.Done});
        else passCnt++;
        totalCnt++;
        if ({bus.Hi, bus.Lo} !== 64'h0) $display("FAIL async_reset_result: got %h_%h expected 0_0", bus.Hi, bus.Lo);
        else passCnt++;
        lastHi = 32'h0;
        lastLo = 32'h0;
        @(negedge Clk);
        Reset = 1'b1;
        runOp("post_reset_3x4", 1'b0, 32'd3, 32'd4);
    endtask

    task automatic test_random();
        logic op;
        logic [31:0] a, b;
        int sel;
        for (int i = 0; i < 25; i++) begin
            op  = 1'($urandom_range(0, 1));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'h0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 15));
                3:       begin a = 32'h80000000; b = $urandom; end
                default: b = $urandom;
            endcase
            runOp($sformatf("random_%0d", i), op, a, b);
        end
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.Op    = 1'b0;
        bus.A     = 32'h0;
        bus.B     = 32'h0;
        Reset     = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_busy_ignore();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
